// File: rtl/ahb_lite_arbiter.sv
// ahb_lite_arbiter: shares one AHB-Lite slave port between N_MST masters (round-robin, burst lock).
// Latency: parked owner reaches the slave in the same cycle; a captured address is replayed 1 cycle later.
// Backpressure: slave wait states freeze grant/lock/hold/pend; a master with a held address sees m_hready=0.
// Ports: HCLK/HRESET; m_* are packed per-master buses (slice i = master i); s_* is the single slave port,
//        m_hrdata is broadcast, m_hready/m_hresp are routed per master.
module ahb_lite_arbiter #(
  parameter int N_MST  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [N_MST*ADDR_W-1:0]   m_haddr,
  input  logic [2*N_MST-1:0]        m_htrans,
  input  logic [N_MST-1:0]          m_hwrite,
  input  logic [3*N_MST-1:0]        m_hsize,
  input  logic [3*N_MST-1:0]        m_hburst,
  input  logic [4*N_MST-1:0]        m_hprot,
  input  logic [N_MST*DATA_W-1:0]   m_hwdata,
  output logic [DATA_W-1:0]         m_hrdata,
  output logic [N_MST-1:0]          m_hready,
  output logic [N_MST-1:0]          m_hresp,
  output logic                      s_hsel,
  output logic [ADDR_W-1:0]         s_haddr,
  output logic [1:0]                s_htrans,
  output logic                      s_hwrite,
  output logic [2:0]                s_hsize,
  output logic [2:0]                s_hburst,
  output logic [3:0]                s_hprot,
  output logic [DATA_W-1:0]         s_hwdata,
  output logic                      s_hready,
  input  logic [DATA_W-1:0]         s_hrdata,
  input  logic                      s_hreadyout,
  input  logic                      s_hresp
);
  localparam int GW = (N_MST > 1) ? $clog2(N_MST) : 1;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BU_SINGLE = 3'b000;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        trans;
    logic              write;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [3:0]        prot;
  } hdr_t;

  typedef enum logic {UNLOCKED, LOCKED} lock_e;

  hdr_t             live   [N_MST];
  hdr_t             hold_q [N_MST];
  hdr_t             hold_d [N_MST];
  hdr_t             fwd;
  logic [1:0]       fwd_trans;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    downer_q, downer_d;
  logic             dvalid_q, dvalid_d;
  logic [N_MST-1:0] pend_q, pend_d;
  lock_e            lock_q, lock_d;
  logic [3:0]       beat_q, beat_d;
  logic [N_MST-1:0] own, hready_int, cap, req;
  logic [GW-1:0]    idx;
  logic             found;
  logic             accept;

  assign accept = s_hreadyout;

  always_comb begin
    for (int i = 0; i < N_MST; i++) begin
      live[i].addr  = m_haddr[i*ADDR_W +: ADDR_W];
      live[i].trans = m_htrans[2*i +: 2];
      live[i].write = m_hwrite[i];
      live[i].size  = m_hsize[3*i +: 3];
      live[i].burst = m_hburst[3*i +: 3];
      live[i].prot  = m_hprot[4*i +: 4];
    end
  end

  // Owner's address phase: a held (captured) transfer takes priority over the live bus.
  assign fwd       = pend_q[grant_q] ? hold_q[grant_q] : live[grant_q];
  assign fwd_trans = HRESET ? TR_IDLE : fwd.trans;

  assign s_haddr  = fwd.addr;
  assign s_htrans = fwd_trans;
  assign s_hsel   = fwd_trans[1];
  assign s_hwrite = fwd.write;
  assign s_hsize  = fwd.size;
  assign s_hburst = fwd.burst;
  assign s_hprot  = fwd.prot;
  assign s_hready = s_hreadyout;
  assign s_hwdata = m_hwdata[downer_q*DATA_W +: DATA_W];
  assign m_hrdata = s_hrdata;

  always_comb begin
    for (int i = 0; i < N_MST; i++) begin
      own[i] = dvalid_q && (downer_q == GW'(i));
      if (own[i])         hready_int[i] = s_hreadyout;
      else if (pend_q[i]) hready_int[i] = 1'b0;
      else                hready_int[i] = 1'b1;
      // Only non-owners are captured; the owner's address goes straight to the slave.
      cap[i] = accept && (GW'(i) != grant_q) && hready_int[i] && (live[i].trans == TR_NONSEQ);
      req[i] = pend_q[i] || cap[i] || ((GW'(i) == grant_q) && (live[i].trans == TR_NONSEQ));
    end
  end

  assign m_hready = HRESET ? {N_MST{1'b1}} : hready_int;
  assign m_hresp  = HRESET ? {N_MST{1'b0}} : (own & {N_MST{s_hresp}});

  // Burst lock. beat_q==0 while LOCKED marks an undefined-length INCR burst.
  always_comb begin
    lock_d = lock_q;
    beat_d = beat_q;
    if ((lock_q == LOCKED) && s_hresp && !s_hreadyout) begin
      // First ERROR cycle: the burst will not complete, release the bus.
      lock_d = UNLOCKED;
      beat_d = '0;
    end else if (accept) begin
      case (fwd_trans)
        TR_NONSEQ: begin
          if (fwd.burst != BU_SINGLE) begin
            lock_d = LOCKED;
            case (fwd.burst[2:1])
              2'b01:   beat_d = 4'd3;
              2'b10:   beat_d = 4'd7;
              2'b11:   beat_d = 4'd15;
              default: beat_d = 4'd0;
            endcase
          end else begin
            lock_d = UNLOCKED;
            beat_d = '0;
          end
        end
        TR_SEQ: begin
          if (lock_q == LOCKED) begin
            if (beat_q == 4'd1) begin
              lock_d = UNLOCKED;
              beat_d = '0;
            end else if (beat_q != 4'd0) begin
              beat_d = beat_q - 4'd1;
            end
          end
        end
        TR_IDLE: begin
          if ((lock_q == LOCKED) && (beat_q == 4'd0)) begin
            lock_d = UNLOCKED;
          end
        end
        TR_BUSY: ;
      endcase
    end
  end

  // Round-robin: scan from grant_q+1; the current owner is checked last, and with
  // no request at all the grant stays parked.
  always_comb begin
    grant_d = grant_q;
    found   = 1'b0;
    idx     = '0;
    if (accept && (lock_d == UNLOCKED)) begin
      for (int k = 1; k <= N_MST; k++) begin
        idx = GW'((int'(grant_q) + k) % N_MST);
        if (!found && req[idx]) begin
          grant_d = idx;
          found   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pend_d   = pend_q;
    hold_d   = hold_q;
    downer_d = downer_q;
    dvalid_d = dvalid_q;
    if (accept) begin
      pend_d[grant_q] = 1'b0;
      for (int i = 0; i < N_MST; i++) begin
        if (cap[i]) begin
          hold_d[i] = live[i];
          pend_d[i] = 1'b1;
        end
      end
      downer_d = grant_q;
      dvalid_d = fwd_trans[1];
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      grant_q  <= '0;
      pend_q   <= '0;
      lock_q   <= UNLOCKED;
      beat_q   <= '0;
      dvalid_q <= 1'b0;
      downer_q <= '0;
      for (int i = 0; i < N_MST; i++) hold_q[i] <= '0;
    end else begin
      grant_q  <= grant_d;
      pend_q   <= pend_d;
      lock_q   <= lock_d;
      beat_q   <= beat_d;
      dvalid_q <= dvalid_d;
      downer_q <= downer_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// Directed bench for ahb_lite_arbiter with two masters: per-cycle vectors with
// hand-computed slave-side address phase, per-master ready/resp and write-data routing.
module tb_ahb_lite_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;
  localparam logic [2:0] SG = 3'b000;
  localparam logic [2:0] I4 = 3'b011;
  localparam logic [2:0] I8 = 3'b101;
  localparam logic [31:0] WD0 = 32'hAAAA_0000;
  localparam logic [31:0] WD1 = 32'hBBBB_0001;

  logic            HCLK = 1'b0;
  logic            HRESET;
  logic [N*AW-1:0] m_haddr;
  logic [2*N-1:0]  m_htrans;
  logic [N-1:0]    m_hwrite;
  logic [3*N-1:0]  m_hsize;
  logic [3*N-1:0]  m_hburst;
  logic [4*N-1:0]  m_hprot;
  logic [N*DW-1:0] m_hwdata;
  logic [DW-1:0]   m_hrdata;
  logic [N-1:0]    m_hready;
  logic [N-1:0]    m_hresp;
  logic            s_hsel;
  logic [AW-1:0]   s_haddr;
  logic [1:0]      s_htrans;
  logic            s_hwrite;
  logic [2:0]      s_hsize;
  logic [2:0]      s_hburst;
  logic [3:0]      s_hprot;
  logic [DW-1:0]   s_hwdata;
  logic            s_hready;
  logic [DW-1:0]   s_hrdata;
  logic            s_hreadyout;
  logic            s_hresp;

  always #5 HCLK = ~HCLK;

  ahb_lite_arbiter #(.N_MST(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
    .m_hburst(m_hburst), .m_hprot(m_hprot), .m_hwdata(m_hwdata),
    .m_hrdata(m_hrdata), .m_hready(m_hready), .m_hresp(m_hresp),
    .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
    .s_hsize(s_hsize), .s_hburst(s_hburst), .s_hprot(s_hprot), .s_hwdata(s_hwdata),
    .s_hready(s_hready), .s_hrdata(s_hrdata), .s_hreadyout(s_hreadyout), .s_hresp(s_hresp)
  );

  // One record per cycle: master/slave inputs and expected outputs in that cycle.
  // ewd: expected data-phase owner driving s_hwdata (2 = not checked).
  typedef struct {
    logic        rst;
    logic [1:0]  t0;
    logic [31:0] a0;
    logic [2:0]  b0;
    logic [1:0]  t1;
    logic [31:0] a1;
    logic [2:0]  b1;
    logic        rdy;
    logic        resp;
    logic [1:0]  et;
    logic [31:0] ea;
    logic [1:0]  erdy;
    logic [1:0]  eresp;
    int          ewd;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;
  int step   = 0;

  function automatic vec_t mk(input logic rst,
                              input logic [1:0] t0, input logic [31:0] a0, input logic [2:0] b0,
                              input logic [1:0] t1, input logic [31:0] a1, input logic [2:0] b1,
                              input logic rdy, input logic resp,
                              input logic [1:0] et, input logic [31:0] ea,
                              input logic [1:0] erdy, input logic [1:0] eresp, input int ewd);
    vec_t v;
    v.rst = rst; v.t0 = t0; v.a0 = a0; v.b0 = b0; v.t1 = t1; v.a1 = a1; v.b1 = b1;
    v.rdy = rdy; v.resp = resp; v.et = et; v.ea = ea; v.erdy = erdy; v.eresp = eresp; v.ewd = ewd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic run(input string tag, input vec_t v);
    logic [31:0] rdat;
    @(posedge HCLK);
    #1;
    step++;
    rdat        = 32'hD000_0000 + 32'(step);
    HRESET      = v.rst;
    m_htrans    = {v.t1, v.t0};
    m_haddr     = {v.a1, v.a0};
    m_hburst    = {v.b1, v.b0};
    s_hreadyout = v.rdy;
    s_hresp     = v.resp;
    s_hrdata    = rdat;
    @(negedge HCLK);
    check($sformatf("%s#%0d s_htrans", tag, step), 32'(s_htrans), 32'(v.et));
    check($sformatf("%s#%0d s_hsel", tag, step), 32'(s_hsel), 32'(v.et[1]));
    if (v.et != ID)
      check($sformatf("%s#%0d s_haddr", tag, step), s_haddr, v.ea);
    check($sformatf("%s#%0d m_hready", tag, step), 32'(m_hready), 32'(v.erdy));
    check($sformatf("%s#%0d m_hresp", tag, step), 32'(m_hresp), 32'(v.eresp));
    check($sformatf("%s#%0d s_hready", tag, step), 32'(s_hready), 32'(v.rdy));
    check($sformatf("%s#%0d m_hrdata", tag, step), m_hrdata, rdat);
    if (v.ewd != 2)
      check($sformatf("%s#%0d s_hwdata", tag, step), s_hwdata, (v.ewd == 1) ? WD1 : WD0);
  endtask

  initial begin
    HRESET      = 1'b1;
    m_htrans    = '0;
    m_haddr     = '0;
    m_hburst    = '0;
    m_hwrite    = 2'b01;
    m_hsize     = {3'd2, 3'd2};
    m_hprot     = {4'h3, 4'h3};
    m_hwdata    = {WD1, WD0};
    s_hreadyout = 1'b1;
    s_hresp     = 1'b0;
    s_hrdata    = '0;

    // Reset
    tbl.push_back(mk(1, ID,0,SG, ID,0,SG, 1,0, ID,0,       2'b11,2'b00, 2));
    tbl.push_back(mk(1, ID,0,SG, ID,0,SG, 1,0, ID,0,       2'b11,2'b00, 0));
    // T2: simultaneous SINGLEs, M0 parked; M1 replayed next cycle, then one wait state on its data
    tbl.push_back(mk(0, NS,32'h100,SG, NS,32'h200,SG, 1,0, NS,32'h100, 2'b11,2'b00, 0));
    tbl.push_back(mk(0, ID,0,SG, ID,0,SG, 1,0, NS,32'h200, 2'b01,2'b00, 0));
    tbl.push_back(mk(0, ID,0,SG, ID,0,SG, 0,0, ID,0,       2'b01,2'b00, 1));
    tbl.push_back(mk(0, ID,0,SG, ID,0,SG, 1,0, ID,0,       2'b11,2'b00, 1));
    // T3: M0 INCR4 (replayed, grant parked at M1), M1 NONSEQ mid-burst waits until the end
    tbl.push_back(mk(0, NS,32'h0,I4, ID,0,SG, 1,0, ID,0,         2'b11,2'b00, 1));
    tbl.push_back(mk(0, SQ,32'h4,I4, ID,0,SG, 1,0, NS,32'h0,     2'b10,2'b00, 1));
    tbl.push_back(mk(0, SQ,32'h4,I4, NS,32'h300,SG, 1,0, SQ,32'h4, 2'b11,2'b00, 0));
    tbl.push_back(mk(0, SQ,32'h8,I4, ID,0,SG, 1,0, SQ,32'h8,     2'b01,2'b00, 0));
    tbl.push_back(mk(0, SQ,32'hC,I4, ID,0,SG, 1,0, SQ,32'hC,     2'b01,2'b00, 0));
    tbl.push_back(mk(0, ID,0,SG, ID,0,SG, 1,0, NS,32'h300,       2'b01,2'b00, 0));
    tbl.push_back(mk(0, ID,0,SG, ID,0,SG, 1,0, ID,0,             2'b11,2'b00, 1));
    // T5: both masters stream SINGLEs; grants alternate
    tbl.push_back(mk(0, NS,32'h1000,SG, NS,32'h2000,SG, 1,0, NS,32'h2000, 2'b11,2'b00, 1));
    tbl.push_back(mk(0, NS,32'h1004,SG, NS,32'h2004,SG, 1,0, NS,32'h1000, 2'b10,2'b00, 1));
    tbl.push_back(mk(0, NS,32'h1004,SG, NS,32'h2008,SG, 1,0, NS,32'h2004, 2'b01,2'b00, 0));
    tbl.push_back(mk(0, NS,32'h1008,SG, NS,32'h2008,SG, 1,0, NS,32'h1004, 2'b10,2'b00, 1));
    tbl.push_back(mk(0, NS,32'h1008,SG, NS,32'h200C,SG, 1,0, NS,32'h2008, 2'b01,2'b00, 0));
    tbl.push_back(mk(0, NS,32'h100C,SG, NS,32'h200C,SG, 1,0, NS,32'h1008, 2'b10,2'b00, 1));
    tbl.push_back(mk(0, NS,32'h100C,SG, NS,32'h2010,SG, 1,0, NS,32'h200C, 2'b01,2'b00, 0));
    tbl.push_back(mk(0, NS,32'h1010,SG, NS,32'h2010,SG, 1,0, NS,32'h100C, 2'b10,2'b00, 1));
    tbl.push_back(mk(0, NS,32'h1010,SG, ID,0,SG,        1,0, NS,32'h2010, 2'b01,2'b00, 0));
    tbl.push_back(mk(0, ID,0,SG, ID,0,SG,               1,0, NS,32'h1010, 2'b10,2'b00, 1));
    tbl.push_back(mk(0, ID,0,SG, ID,0,SG,               1,0, ID,0,        2'b11,2'b00, 0));

    foreach (tbl[i]) run("tbl", tbl[i]);

    // T4: three wait states on beat 2 of M0 INCR4 with M1 held
    run("wait", mk(0, NS,32'h40,I4, ID,0,SG,         1,0, NS,32'h40, 2'b11,2'b00, 0));
    run("wait", mk(0, SQ,32'h44,I4, NS,32'h500,SG,   1,0, SQ,32'h44, 2'b11,2'b00, 0));
    for (int w = 0; w < 3; w++)
      run("wait", mk(0, SQ,32'h48,I4, ID,0,SG,       0,0, SQ,32'h48, 2'b00,2'b00, 0));
    run("wait", mk(0, SQ,32'h48,I4, ID,0,SG,         1,0, SQ,32'h48, 2'b01,2'b00, 0));
    run("wait", mk(0, SQ,32'h4C,I4, ID,0,SG,         1,0, SQ,32'h4C, 2'b01,2'b00, 0));
    run("wait", mk(0, ID,0,SG, ID,0,SG,              1,0, NS,32'h500, 2'b01,2'b00, 0));
    run("wait", mk(0, ID,0,SG, ID,0,SG,              1,0, ID,0,       2'b11,2'b00, 1));

    // T6: ERROR on beat 2 of M0 INCR8, M0 goes IDLE, held M1 takes the bus
    run("err", mk(0, NS,32'h80,I8, ID,0,SG,          1,0, ID,0,       2'b11,2'b00, 1));
    run("err", mk(0, SQ,32'h84,I8, ID,0,SG,          1,0, NS,32'h80,  2'b10,2'b00, 1));
    run("err", mk(0, SQ,32'h84,I8, NS,32'h600,SG,    1,0, SQ,32'h84,  2'b11,2'b00, 0));
    run("err", mk(0, SQ,32'h88,I8, ID,0,SG,          0,1, SQ,32'h88,  2'b00,2'b01, 0));
    run("err", mk(0, ID,0,SG, ID,0,SG,               1,1, ID,0,       2'b01,2'b01, 0));
    run("err", mk(0, ID,0,SG, ID,0,SG,               1,0, NS,32'h600, 2'b01,2'b00, 0));
    run("err", mk(0, ID,0,SG, ID,0,SG,               1,0, ID,0,       2'b11,2'b00, 1));

    // T1: reset for two cycles in the middle of an M1 INCR4, slave not ready during reset
    run("rst", mk(0, ID,0,SG, NS,32'h700,I4,         1,0, NS,32'h700, 2'b11,2'b00, 1));
    run("rst", mk(0, ID,0,SG, SQ,32'h704,I4,         1,0, SQ,32'h704, 2'b11,2'b00, 1));
    run("rst", mk(1, ID,0,SG, SQ,32'h708,I4,         0,0, ID,0,       2'b11,2'b00, 2));
    run("rst", mk(1, ID,0,SG, SQ,32'h708,I4,         0,0, ID,0,       2'b11,2'b00, 0));
    run("rst", mk(0, NS,32'h900,SG, ID,0,SG,         1,0, NS,32'h900, 2'b11,2'b00, 0));
    run("rst", mk(0, ID,0,SG, ID,0,SG,               1,0, ID,0,       2'b11,2'b00, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
